// File: rtl/operand_loader.sv
// operand_loader: front end for the N-bit less-than comparator on the Basys3 board.
// It synchronizes the slide switches and the load push-button, debounces the button,
// and captures operand a then operand b on successive presses. A third press drops
// valid and starts over.
//
// Optional feature (macro OPERAND_LOADER_SWAP_EN): adds btn_swap. A swap press in
// READY exchanges a and b. If a load press lands on the same edge, the load press wins.
//
// Ports:
//   clk       in   1  system clock, rising edge
//   reset     in   1  asynchronous active-high reset
//   sw        in   N  raw slide switches (asynchronous)
//   btn_load  in   1  raw load push-button (asynchronous, bouncy)
//   btn_swap  in   1  raw swap push-button (only with OPERAND_LOADER_SWAP_EN)
//   a         out  N  captured operand A
//   b         out  N  captured operand B
//   valid     out  1  a/b form a complete pair (READY only)
//   state     out  2  FSM state code for LEDs (00 LOAD_A, 01 LOAD_B, 10 READY)
module operand_loader #(
   parameter int unsigned N               = 3,
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] sw,
   input  logic         btn_load,
`ifdef OPERAND_LOADER_SWAP_EN
   input  logic         btn_swap,
`endif
   output logic [N-1:0] a,
   output logic [N-1:0] b,
   output logic         valid,
   output logic [1:0]   state
);

   localparam int unsigned      CntW   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      StLoadA = 2'b00,
      StLoadB = 2'b01,
      StReady = 2'b10
   } state_e;

   // Two-flop synchronizers for the switches and the load button
   logic [N-1:0] sw_meta_q, sw_sync_q;
   logic         ld_meta_q, ld_sync_q;

   // Load button debounce state
   logic [CntW-1:0] ld_cnt_q, ld_cnt_d;
   logic            ld_db_q, ld_db_d;
   logic            ld_db_dly_q;
   logic            press_load;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sw_meta_q   <= '0;
         sw_sync_q   <= '0;
         ld_meta_q   <= 1'b0;
         ld_sync_q   <= 1'b0;
         ld_cnt_q    <= '0;
         ld_db_q     <= 1'b0;
         ld_db_dly_q <= 1'b0;
      end else begin
         sw_meta_q   <= sw;
         sw_sync_q   <= sw_meta_q;
         ld_meta_q   <= btn_load;
         ld_sync_q   <= ld_meta_q;
         ld_cnt_q    <= ld_cnt_d;
         ld_db_q     <= ld_db_d;
         ld_db_dly_q <= ld_db_q;
      end
   end

   // The synchronized level must differ from db for DEBOUNCE_CYCLES straight cycles
   always_comb begin
      ld_cnt_d = ld_cnt_q;
      ld_db_d  = ld_db_q;
      if (ld_sync_q == ld_db_q) begin
         ld_cnt_d = '0;
      end else if (ld_cnt_q == CntMax) begin
         ld_db_d  = ld_sync_q;
         ld_cnt_d = '0;
      end else begin
         ld_cnt_d = ld_cnt_q + CntW'(1);
      end
   end

   assign press_load = ld_db_q & ~ld_db_dly_q;

`ifdef OPERAND_LOADER_SWAP_EN
   logic            sp_meta_q, sp_sync_q;
   logic [CntW-1:0] sp_cnt_q, sp_cnt_d;
   logic            sp_db_q, sp_db_d;
   logic            sp_db_dly_q;
   logic            press_swap;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sp_meta_q   <= 1'b0;
         sp_sync_q   <= 1'b0;
         sp_cnt_q    <= '0;
         sp_db_q     <= 1'b0;
         sp_db_dly_q <= 1'b0;
      end else begin
         sp_meta_q   <= btn_swap;
         sp_sync_q   <= sp_meta_q;
         sp_cnt_q    <= sp_cnt_d;
         sp_db_q     <= sp_db_d;
         sp_db_dly_q <= sp_db_q;
      end
   end

   always_comb begin
      sp_cnt_d = sp_cnt_q;
      sp_db_d  = sp_db_q;
      if (sp_sync_q == sp_db_q) begin
         sp_cnt_d = '0;
      end else if (sp_cnt_q == CntMax) begin
         sp_db_d  = sp_sync_q;
         sp_cnt_d = '0;
      end else begin
         sp_cnt_d = sp_cnt_q + CntW'(1);
      end
   end

   assign press_swap = sp_db_q & ~sp_db_dly_q;
`endif

   // Operand capture FSM with registered outputs
   state_e       state_q;
   logic [N-1:0] a_q, b_q;
   logic         valid_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StLoadA;
         a_q     <= '0;
         b_q     <= '0;
         valid_q <= 1'b0;
      end else begin
         case (state_q)
            StLoadA: begin
               if (press_load) begin
                  a_q     <= sw_sync_q;
                  state_q <= StLoadB;
               end
            end
            StLoadB: begin
               if (press_load) begin
                  b_q     <= sw_sync_q;
                  valid_q <= 1'b1;
                  state_q <= StReady;
               end
            end
            StReady: begin
               if (press_load) begin
                  valid_q <= 1'b0;
                  state_q <= StLoadA;
               end
`ifdef OPERAND_LOADER_SWAP_EN
               else if (press_swap) begin
                  a_q <= b_q;
                  b_q <= a_q;
               end
`endif
            end
            default: begin
               // 2'b11 is unreachable; recover to a clean LOAD_A
               valid_q <= 1'b0;
               state_q <= StLoadA;
            end
         endcase
      end
   end

   assign a     = a_q;
   assign b     = b_q;
   assign valid = valid_q;
   assign state = state_q;

endmodule

// File: tb/tb_operand_loader.sv
// Self-checking bench for operand_loader (N=3, DEBOUNCE_CYCLES=4, 10 ns clock).
// Table-driven load sequence plus hand-written multi-cycle corner cases.
module tb_operand_loader;

   localparam int unsigned N  = 3;
   localparam int unsigned DB = 4;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [N-1:0] sw = '0;
   logic         btn_load = 1'b0;
   logic         btn_swap = 1'b0;
   logic [N-1:0] a, b;
   logic         valid;
   logic [1:0]   state;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   operand_loader #(
      .N               (N),
      .DEBOUNCE_CYCLES (DB)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .sw       (sw),
      .btn_load (btn_load),
`ifdef OPERAND_LOADER_SWAP_EN
      .btn_swap (btn_swap),
`endif
      .a        (a),
      .b        (b),
      .valid    (valid),
      .state    (state)
   );

   typedef struct {
      logic [N-1:0] sw_v;
      logic [N-1:0] exp_a;
      logic [N-1:0] exp_b;
      logic         exp_valid;
      logic [1:0]   exp_state;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Advance one edge and settle 1 ns after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      btn_load = 1'b0;
      btn_swap = 1'b0;
      repeat (2) tick();
      reset = 1'b0;
      repeat (2) tick();
   endtask

   // Clean press of either/both buttons, held long enough to accept, then released
   task automatic press(input logic [N-1:0] swv, input logic ld, input logic sp);
      sw = swv;
      btn_load = ld;
      btn_swap = sp;
      repeat (10) tick();
      btn_load = 1'b0;
      btn_swap = 1'b0;
      repeat (10) tick();
   endtask

   task automatic chk_out(input string tag, input logic [N-1:0] ea, input logic [N-1:0] eb,
                          input logic ev, input logic [1:0] es);
      chk({tag, ".a"}, 32'(a), 32'(ea));
      chk({tag, ".b"}, 32'(b), 32'(eb));
      chk({tag, ".valid"}, 32'(valid), 32'(ev));
      chk({tag, ".state"}, 32'(state), 32'(es));
   endtask

   vec_t vecs[8];

   initial begin
      vecs[0] = '{3'b101, 3'b101, 3'b000, 1'b0, 2'b01};
      vecs[1] = '{3'b110, 3'b101, 3'b110, 1'b1, 2'b10};
      vecs[2] = '{3'b011, 3'b101, 3'b110, 1'b0, 2'b00};
      vecs[3] = '{3'b011, 3'b011, 3'b110, 1'b0, 2'b01};
      vecs[4] = '{3'b000, 3'b011, 3'b000, 1'b1, 2'b10};
      vecs[5] = '{3'b111, 3'b011, 3'b000, 1'b0, 2'b00};
      vecs[6] = '{3'b111, 3'b111, 3'b000, 1'b0, 2'b01};
      vecs[7] = '{3'b001, 3'b111, 3'b001, 1'b1, 2'b10};

      // Idle after reset: everything stays cleared
      do_reset();
      for (int i = 0; i < 50; i++) begin
         tick();
         chk("idle", 32'({a, b, valid, state}), 32'd0);
      end

      // Latency: button high from E1, capture exactly on E7
      sw = 3'b101;
      repeat (3) tick();
      btn_load = 1'b1;
      for (int e = 1; e <= 6; e++) begin
         tick();
         chk("lat.early", 32'({a, state}), 32'({3'b000, 2'b00}));
      end
      tick();
      chk("lat.E7.a", 32'(a), 32'(3'b101));
      chk("lat.E7.state", 32'(state), 32'(2'b01));
      // Held for 100 cycles: still a single capture, with sw changed under it
      sw = 3'b011;
      repeat (100) tick();
      chk_out("held", 3'b101, 3'b000, 1'b0, 2'b01);
      btn_load = 1'b0;
      repeat (10) tick();

      // Bounce: 3 high, 1 low, 2 high never reaches 4 consecutive cycles
      btn_load = 1'b1; repeat (3) tick();
      btn_load = 1'b0; repeat (1) tick();
      btn_load = 1'b1; repeat (2) tick();
      btn_load = 1'b0; repeat (15) tick();
      chk_out("bounce", 3'b101, 3'b000, 1'b0, 2'b01);

      // Table-driven load/ready cycles from a fresh reset
      do_reset();
      foreach (vecs[i]) begin
         press(vecs[i].sw_v, 1'b1, 1'b0);
         chk_out($sformatf("vec%0d", i), vecs[i].exp_a, vecs[i].exp_b, vecs[i].exp_valid,
                 vecs[i].exp_state);
      end

      // Switch changes in READY do not reach the outputs
      sw = 3'b010;
      repeat (20) tick();
      chk_out("swtoggle", 3'b111, 3'b001, 1'b1, 2'b10);

      // Async reset mid-debounce (counter = 2) clears outputs before any edge
      btn_load = 1'b1;
      repeat (4) tick();
      reset = 1'b1;
      #1;
      chk_out("midrst", 3'b000, 3'b000, 1'b0, 2'b00);
      btn_load = 1'b0;
      tick();
      reset = 1'b0;
      repeat (3) tick();
      press(3'b100, 1'b1, 1'b0);
      chk_out("postrst", 3'b100, 3'b000, 1'b0, 2'b01);

`ifdef OPERAND_LOADER_SWAP_EN
      do_reset();
      press(3'b010, 1'b1, 1'b0);
      press(3'b110, 1'b1, 1'b0);
      chk_out("sw.ready", 3'b010, 3'b110, 1'b1, 2'b10);
      press(3'b000, 1'b0, 1'b1);
      chk_out("sw.swap", 3'b110, 3'b010, 1'b1, 2'b10);
      press(3'b000, 1'b1, 1'b1);
      chk_out("sw.both", 3'b110, 3'b010, 1'b0, 2'b00);
      press(3'b001, 1'b1, 1'b0);
      press(3'b000, 1'b0, 1'b1);
      chk_out("sw.loadb", 3'b001, 3'b010, 1'b0, 2'b01);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
